// File: rtl/prng_pkg.sv
// ============================================================================
// Package    : prng_pkg
// Description: Shared FSM encoding, default constants and the clog2 helper
//              for the PRNG request arbiter.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package prng_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_RANGE     = 10;
  localparam int DEF_STEPS     = 4;
  localparam int DEF_MAX_RETRY = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prng_arbiter_rr_picker.sv
// ============================================================================
// Module     : rr_picker
// Description: Combinational round-robin selector: first set request bit at
//              or after the pointer, wrapping.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  rr_ptr_i,
  output logic [ID_W-1:0]  gnt_id_o,
  output logic             any_req_o
);

  int idx_w;

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    gnt_id_o  = '0;
    any_req_o = 1'b0;
    idx_w     = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx_w = int'(rr_ptr_i) + i;
      if (idx_w >= N_REQ) idx_w = idx_w - N_REQ;
      if (req_i[idx_w]) begin
        gnt_id_o  = idx_w[ID_W-1:0];
        any_req_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/prng_arbiter.sv
// ============================================================================
// Module     : prng_arbiter
// Description: Shares one LFSR between requesters, sequences its enable and
//              returns rejection-sampled values in 0..RANGE-1.
//              Optional macro PRNG_ARB_STATS_EN adds draw/reject counters.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module prng_arbiter
  import prng_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int RANGE     = DEF_RANGE,
  parameter int STEPS     = DEF_STEPS,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] ack,
  output logic [7:0]       rand_data,
  output logic             busy,
  output logic             prng_en,
  input  logic [7:0]       prng_raw
`ifdef PRNG_ARB_STATS_EN
  ,
  output logic [15:0]      draw_cnt,
  output logic [15:0]      reject_cnt
`endif
);

  localparam int         VAL_W   = clog2(RANGE);
  localparam int         ID_W    = (N_REQ > 1) ? clog2(N_REQ) : 1;
  localparam logic [8:0] RANGE_W = 9'(RANGE);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2:0]         retry_q, retry_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [7:0]         data_q, data_d;

  logic [ID_W-1:0]    pick_w;
  logic               any_w;
  logic [8:0]         cand_w;
  logic               accept_w;
  logic               unused_raw_w;

  assign unused_raw_w = ^prng_raw;

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_picker (
    .req_i     (req),
    .rr_ptr_i  (rr_q),
    .gnt_id_o  (pick_w),
    .any_req_o (any_w)
  );

  // Candidate is at most 2*RANGE-1, so a single subtraction folds it in range.
  assign cand_w   = 9'(prng_raw[VAL_W-1:0]);
  assign accept_w = (cand_w < RANGE_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      retry_q <= '0;
      ack_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    ack_d   = '0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (any_w) begin
          gnt_d   = pick_w;
          cnt_d   = 4'(STEPS);
          retry_d = '0;
          state_d = STEP;
        end
      end
      STEP: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = CHECK;
      end
      CHECK: begin
        if (accept_w) begin
          data_d        = 8'(cand_w);
          ack_d[gnt_q]  = 1'b1;
          state_d       = DONE;
        end else if (retry_q < 3'(MAX_RETRY)) begin
          retry_d = retry_q + 3'd1;
          cnt_d   = 4'd1;
          state_d = STEP;
        end else begin
          data_d        = 8'(cand_w - RANGE_W);
          ack_d[gnt_q]  = 1'b1;
          state_d       = DONE;
        end
      end
      DONE: begin
        rr_d    = (gnt_q == ID_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack       = ack_q;
  assign rand_data = data_q;
  assign busy      = (state_q != IDLE);
  assign prng_en   = (state_q == STEP);

`ifdef PRNG_ARB_STATS_EN
  logic [15:0] draw_q;
  logic [15:0] rej_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      draw_q <= '0;
      rej_q  <= '0;
    end else begin
      if (state_q == DONE && draw_q != 16'hFFFF) draw_q <= draw_q + 16'd1;
      if (state_q == CHECK && !accept_w && rej_q != 16'hFFFF) rej_q <= rej_q + 16'd1;
    end
  end

  assign draw_cnt   = draw_q;
  assign reject_cnt = rej_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prng_arbiter.sv
// ============================================================================
// Module     : tb_prng_arbiter
// Description: Self-checking bench for prng_arbiter: directed vectors, corner
//              sequences and LFSR-driven random draws against a draw model.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_prng_arbiter;

  localparam int NR = 4;
  localparam int RG = 10;
  localparam int ST = 4;
  localparam int MR = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR-1:0] ack;
  logic [7:0]    rand_data;
  logic          busy;
  logic          prng_en;
  logic [7:0]    prng_raw;
`ifdef PRNG_ARB_STATS_EN
  logic [15:0]   draw_cnt;
  logic [15:0]   reject_cnt;
`endif

  logic          raw_sel;
  logic [7:0]    raw_fix;
  logic [15:0]   lfsr_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prng_arbiter #(
    .N_REQ     (NR),
    .RANGE     (RG),
    .STEPS     (ST),
    .MAX_RETRY (MR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ack       (ack),
    .rand_data (rand_data),
    .busy      (busy),
    .prng_en   (prng_en),
    .prng_raw  (prng_raw)
`ifdef PRNG_ARB_STATS_EN
    ,
    .draw_cnt  (draw_cnt),
    .reject_cnt(reject_cnt)
`endif
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Bench-side PRNG instance: raw byte reflects the previous cycle's enable.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else if (prng_en) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign prng_raw = raw_sel ? lfsr_q[7:0] : raw_fix;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input bit check_outputs);
    rst_n = 1'b0;
    req   = '0;
    #1;
    if (check_outputs) begin
      chk("reset ack", int'(ack), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset prng_en", int'(prng_en), 0);
      chk("reset rand_data", int'(rand_data), 0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Cycle 0 is the cycle in which req is first presented to an idle DUT.
  task automatic run_draw(input logic [NR-1:0] r, input logic [7:0] raw_after, input bit hold,
                          output int ack_cyc, output logic [NR-1:0] ack_v, output logic [7:0] data,
                          output int en_cnt, output int first_en, output bit inv_ok);
    int  cyc;
    bit  got;
    req      = r;
    cyc      = 0;
    got      = 1'b0;
    en_cnt   = 0;
    first_en = -1;
    inv_ok   = 1'b1;
    ack_cyc  = -1;
    ack_v    = '0;
    data     = '0;
    while (!got && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!raw_sel && cyc == 6) raw_fix = raw_after;
      if (prng_en) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        if (!busy || ack != '0) inv_ok = 1'b0;
      end
      if ($countones(ack) > 1) inv_ok = 1'b0;
      if (ack != '0) begin
        got     = 1'b1;
        ack_cyc = cyc;
        ack_v   = ack;
        data    = rand_data;
        if (!hold) req = '0;
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL draw timeout actual=no_ack expected=ack_within_60");
    end else begin
      @(posedge clk);
      #1;
      if (busy || ack != '0 || prng_en) inv_ok = 1'b0;
    end
  endtask

  typedef struct {
    logic [NR-1:0] req;
    logic [7:0]    raw0;
    logic [7:0]    raw1;
    logic [NR-1:0] ack;
    logic [7:0]    data;
    int            cyc;
    int            en;
    int            rej;
  } vec_t;

  vec_t vecs[8];

  // Draw model: STEPS advances, then single-advance re-draws while the low
  // VAL_W bits are out of range, then fold by one RANGE.
  function automatic void model_draw(input logic [15:0] s_in, output logic [15:0] s_out,
                                     output int val, output int retries);
    logic [15:0] s;
    int c;
    s = s_in;
    for (int k = 0; k < ST; k++) s = lfsr_next(s);
    c = int'(s) % 16;
    retries = 0;
    while (c >= RG && retries < MR) begin
      s = lfsr_next(s);
      c = int'(s) % 16;
      retries++;
    end
    if (c >= RG) c = c - RG;
    val   = c;
    s_out = s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            acyc, encnt, fen, val, rtr, id, gap;
    logic [NR-1:0] av, rq;
    logic [7:0]    dv;
    bit            ok;
    logic [15:0]   mdl_lfsr;
    int            mdl_rr;
    int            hist[RG];

    vecs[0] = '{4'b0100, 8'h37, 8'h37, 4'b0100, 8'd7, 6,  4, 0};
    vecs[1] = '{4'b0010, 8'h0C, 8'h05, 4'b0010, 8'd5, 8,  5, 1};
    vecs[2] = '{4'b0001, 8'h0F, 8'h0F, 4'b0001, 8'd5, 12, 7, 4};
    vecs[3] = '{4'b1010, 8'h09, 8'h09, 4'b0010, 8'd9, 6,  4, 0};
    vecs[4] = '{4'b1000, 8'h0A, 8'h03, 4'b1000, 8'd3, 8,  5, 1};
    vecs[5] = '{4'b0001, 8'h20, 8'h20, 4'b0001, 8'd0, 6,  4, 0};
    vecs[6] = '{4'b0100, 8'h0A, 8'h0A, 4'b0100, 8'd0, 12, 7, 4};
    vecs[7] = '{4'b0010, 8'hFE, 8'h1B, 4'b0010, 8'd1, 12, 7, 4};

    raw_sel = 1'b0;
    raw_fix = 8'h37;
    req     = '0;
    rst_n   = 1'b0;
    do_reset(1'b1);

    for (int v = 0; v < 8; v++) begin
      if (v > 0) do_reset(1'b0);
      raw_fix = vecs[v].raw0;
      run_draw(vecs[v].req, vecs[v].raw1, 1'b0, acyc, av, dv, encnt, fen, ok);
      chk($sformatf("vec%0d ack", v), int'(av), int'(vecs[v].ack));
      chk($sformatf("vec%0d data", v), int'(dv), int'(vecs[v].data));
      chk($sformatf("vec%0d ack_cycle", v), acyc, vecs[v].cyc);
      chk($sformatf("vec%0d en_cycles", v), encnt, vecs[v].en);
      chk($sformatf("vec%0d first_en", v), fen, 1);
      chk($sformatf("vec%0d invariants", v), int'(ok), 1);
`ifdef PRNG_ARB_STATS_EN
      chk($sformatf("vec%0d reject_cnt", v), int'(reject_cnt), vecs[v].rej);
      chk($sformatf("vec%0d draw_cnt", v), int'(draw_cnt), 1);
`endif
    end

    // Reset in the middle of a draw; pointer left at 2 by the last vector.
    raw_fix = 8'h37;
    req     = 4'b0100;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("mid prng_en before reset", int'(prng_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid prng_en", int'(prng_en), 0);
    chk("mid busy", int'(busy), 0);
    chk("mid ack", int'(ack), 0);
    chk("mid rand_data", int'(rand_data), 0);
    req = 4'b0110;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_draw(4'b0110, 8'h37, 1'b0, acyc, av, dv, encnt, fen, ok);
    chk("post reset ack", int'(av), 4'b0010);
    chk("post reset ack_cycle", acyc, 6);
    chk("post reset data", int'(dv), 7);

    // Fairness with all requests held.
    do_reset(1'b0);
    raw_fix = 8'h37;
    for (int n = 0; n < 6; n++) begin
      run_draw(4'b1111, 8'h37, 1'b1, acyc, av, dv, encnt, fen, ok);
      chk($sformatf("fair%0d ack", n), int'(av), 1 << (n % NR));
      chk($sformatf("fair%0d ack_cycle", n), acyc, 6);
      chk($sformatf("fair%0d invariants", n), int'(ok), 1);
    end
    req = '0;

    // Random requests against the live LFSR.
    do_reset(1'b0);
    raw_sel  = 1'b1;
    mdl_lfsr = 16'hACE1;
    mdl_rr   = 0;
    for (int k = 0; k < RG; k++) hist[k] = 0;
    for (int n = 0; n < 1000; n++) begin
      rq = NR'($urandom_range(1, (1 << NR) - 1));
      id = -1;
      for (int o = NR - 1; o >= 0; o--) begin
        if (rq[(mdl_rr + o) % NR]) id = (mdl_rr + o) % NR;
      end
      mdl_rr = (id + 1) % NR;
      model_draw(mdl_lfsr, mdl_lfsr, val, rtr);
      run_draw(rq, 8'h00, 1'b0, acyc, av, dv, encnt, fen, ok);
      chk("rand ack", int'(av), 1 << id);
      chk("rand data", int'(dv), val);
      chk("rand latency", acyc, 6 + 2 * rtr);
      chk("rand invariants", int'(ok), 1);
      if (int'(dv) < RG) hist[int'(dv)]++;
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      #1;
    end
    for (int k = 0; k < RG; k++) chk($sformatf("hist value %0d >= 50", k), int'(hist[k] >= 50), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
